nes_clk_scheduler: RTL and testbench

Master-clock sequencer for the console core. Generates CPU and PPU clock-enable strobes from one master clock and keeps the two divide chains phase-locked. Adds run/halt/single-step control, with a req/ack-style handshake, for the debug host. Sits between the master clock domain and every CPU/PPU/APU block, which gate their state with cpu_ce/ppu_ce.

---
 rtl/nes_clk_scheduler.sv | 85 ++++++++
 tb/tb_nes_clk_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nes_clk_scheduler.sv
// rtl/nes_clk_scheduler.sv - CPU/PPU clock-enable sequencer with run/halt/step control
// Optional NES_CLK_LEVEL_OUT_EN adds level clocks cpu_clk/ppu_clk for legacy consumers.
module nes_clk_scheduler #(
  parameter int CPU_DIV      = 12,
  parameter int PPU_DIV      = 4,
  parameter int START_HALTED = 0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             cpu_ce,
  output logic             ppu_ce,
  output logic [3:0]       cpu_phase,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cpu_cycle_count
`ifdef NES_CLK_LEVEL_OUT_EN
  ,
  output logic             cpu_clk,
  output logic             ppu_clk
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_RESET = (START_HALTED != 0) ? ST_HALT : ST_RUN;

  localparam logic [3:0] CPU_LAST = 4'(CPU_DIV - 1);
  localparam logic [3:0] PPU_LAST = 4'(PPU_DIV - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] cpu_cnt;
  logic [3:0] ppu_cnt;
  logic       adv;

  assign adv       = (state == ST_RUN) || (state == ST_STEP);
  assign cpu_ce    = !reset && adv && (cpu_cnt == CPU_LAST);
  assign ppu_ce    = !reset && adv && (ppu_cnt == PPU_LAST);
  assign cpu_phase = cpu_cnt;

`ifdef NES_CLK_LEVEL_OUT_EN
  assign cpu_clk = (cpu_cnt < 4'(CPU_DIV / 2));
  assign ppu_clk = (ppu_cnt < 4'(PPU_DIV / 2));
`endif

  // Halt is only taken on the cpu_ce edge, so HALT always parks at cpu_cnt == 0.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (halt_req && cpu_ce) state_nxt = ST_HALT;
      ST_HALT: begin
        if (!halt_req)     state_nxt = ST_RUN;
        else if (step_req) state_nxt = ST_STEP;
      end
      ST_STEP: if (cpu_ce) state_nxt = ST_HALT;
      default: state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_RESET;
      halted          <= (ST_RESET == ST_HALT);
      cpu_cnt         <= '0;
      ppu_cnt         <= '0;
      step_done       <= 1'b0;
      cpu_cycle_count <= '0;
    end else begin
      state     <= state_nxt;
      halted    <= (state_nxt == ST_HALT);
      step_done <= (state == ST_STEP) && cpu_ce;
      if (adv) begin
        cpu_cnt <= cpu_ce ? 4'd0 : cpu_cnt + 4'd1;
        // ppu_cnt keeps its own phase; it is never realigned to the CPU boundary.
        ppu_cnt <= ppu_ce ? 4'd0 : ppu_cnt + 4'd1;
      end
      cpu_cycle_count <= cpu_cycle_count + CNT_W'(cpu_ce);
    end
  end

endmodule

// File: tb/tb_nes_clk_scheduler.sv
// tb/tb_nes_clk_scheduler.sv - scoreboard bench for nes_clk_scheduler
module tb_nes_clk_scheduler;

  localparam int CPU_DIV = 12;
  localparam int PPU_DIV = 4;
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1, halt_req = 1'b0, step_req = 1'b0;
  logic        cpu_ce, ppu_ce, halted, step_done;
  logic [3:0]  cpu_phase;
  logic [31:0] cpu_cycle_count;

  logic        rst_h = 1'b1, halt_h = 1'b1, step_h = 1'b0;
  logic        h_cpu_ce, h_ppu_ce, h_halted, h_step_done;
  logic [3:0]  h_cpu_phase;
  logic [31:0] h_count;

`ifdef NES_CLK_LEVEL_OUT_EN
  logic cpu_clk, ppu_clk, h_cpu_clk, h_ppu_clk;
`endif

  always #5 clk = ~clk;

  nes_clk_scheduler #(.CPU_DIV(CPU_DIV), .PPU_DIV(PPU_DIV), .START_HALTED(0), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .step_req(step_req),
    .cpu_ce(cpu_ce), .ppu_ce(ppu_ce), .cpu_phase(cpu_phase), .halted(halted),
    .step_done(step_done), .cpu_cycle_count(cpu_cycle_count)
`ifdef NES_CLK_LEVEL_OUT_EN
    , .cpu_clk(cpu_clk), .ppu_clk(ppu_clk)
`endif
  );

  nes_clk_scheduler #(.CPU_DIV(CPU_DIV), .PPU_DIV(PPU_DIV), .START_HALTED(1), .CNT_W(32)) u_halt (
    .clk(clk), .reset(rst_h), .halt_req(halt_h), .step_req(step_h),
    .cpu_ce(h_cpu_ce), .ppu_ce(h_ppu_ce), .cpu_phase(h_cpu_phase), .halted(h_halted),
    .step_done(h_step_done), .cpu_cycle_count(h_count)
`ifdef NES_CLK_LEVEL_OUT_EN
    , .cpu_clk(h_cpu_clk), .ppu_clk(h_ppu_clk)
`endif
  );

  typedef struct {
    bit          chk;
    int          cyc;
    bit          cpu_ce;
    bit          ppu_ce;
    int          phase;
    bit          halted;
    bit          step_done;
    int unsigned count;
    bit          cpu_clk;
    bit          ppu_clk;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: total advancing clocks since reset fully determines both phases and the cycle count.
  bit          m_valid = 0;
  int          m_mode  = M_RUN;
  int unsigned m_adv   = 0;
  bit          m_sdone = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    bit   moving, boundary;
    int   phase;
    phase    = int'(m_adv % CPU_DIV);
    moving   = (m_mode != M_HALT);
    boundary = moving && (phase == CPU_DIV - 1);
    e.chk       = m_valid;
    e.cyc       = cyc;
    e.cpu_ce    = !reset && boundary;
    e.ppu_ce    = !reset && moving && (m_adv % PPU_DIV == PPU_DIV - 1);
    e.phase     = phase;
    e.halted    = (m_mode == M_HALT);
    e.step_done = m_sdone;
    e.count     = m_adv / CPU_DIV;
    e.cpu_clk   = (phase < CPU_DIV / 2);
    e.ppu_clk   = (m_adv % PPU_DIV < PPU_DIV / 2);
    q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_valid = 1; m_mode = M_RUN; m_adv = 0; m_sdone = 0;
    end else if (m_valid) begin
      m_sdone = (m_mode == M_STEP) && boundary;
      case (m_mode)
        M_RUN:  if (halt_req && boundary) m_mode = M_HALT;
        M_HALT: if (!halt_req) m_mode = M_RUN; else if (step_req) m_mode = M_STEP;
        default: if (boundary) m_mode = M_HALT;
      endcase
      if (moving) m_adv++;
    end
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        chk("sb_cpu_ce", cpu_ce, e.cpu_ce);
        chk("sb_ppu_ce", ppu_ce, e.ppu_ce);
        chk("sb_cpu_phase", cpu_phase, e.phase);
        chk("sb_halted", halted, e.halted);
        chk("sb_step_done", step_done, e.step_done);
        chk("sb_count", cpu_cycle_count, e.count);
`ifdef NES_CLK_LEVEL_OUT_EN
        chk("sb_cpu_clk", cpu_clk, e.cpu_clk);
        chk("sb_ppu_clk", ppu_clk, e.ppu_clk);
`endif
      end
    end
  end

  initial begin
    int n, n_cpu, n_ppu, n_sd;
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_phase", cpu_phase, 0);
    reset = 1'b0;
    rst_h = 1'b0;

    // Free run from reset: two CPU cycles, six PPU dots.
    n_cpu = 0; n_ppu = 0;
    for (int i = 0; i < 24; i++) begin
      n_cpu += int'(cpu_ce); n_ppu += int'(ppu_ce);
      tick();
    end
    chk("run24_cpu_ce", n_cpu, 2);
    chk("run24_ppu_ce", n_ppu, 6);
    chk("run24_count", cpu_cycle_count, 2);
    chk("h_reset_halted", h_halted, 1);
    chk("h_reset_phase", h_cpu_phase, 0);

    // Halt requested mid-cycle lands on the next boundary.
    n = 0;
    while (cpu_phase != 4'd4 && n < 20) begin tick(); n++; end
    chk("reach_phase4", cpu_phase, 4);
    halt_req = 1'b1;
    n = 0;
    while (!halted && n < 40) begin tick(); n++; end
    chk("halt_latency", n, 8);
    chk("halt_phase", cpu_phase, 0);
    n_cpu = 0; n_ppu = 0;
    for (int i = 0; i < 50; i++) begin
      n_cpu += int'(cpu_ce); n_ppu += int'(ppu_ce);
      tick();
    end
    chk("halt_no_cpu_ce", n_cpu, 0);
    chk("halt_no_ppu_ce", n_ppu, 0);
    chk("halt_count", cpu_cycle_count, 3);

    // Single step from HALT.
    step_req = 1'b1; tick(); step_req = 1'b0;
    n_cpu = 0; n_ppu = 0; n_sd = 0;
    for (int i = 0; i < 15; i++) begin
      n_cpu += int'(cpu_ce); n_ppu += int'(ppu_ce); n_sd += int'(step_done);
      tick();
    end
    chk("step_cpu_ce", n_cpu, 1);
    chk("step_ppu_ce", n_ppu, 3);
    chk("step_done_pulses", n_sd, 1);
    chk("step_halted", halted, 1);
    chk("step_count", cpu_cycle_count, 4);

    // Release and step on the same clk: run wins.
    halt_req = 1'b0; step_req = 1'b1; tick(); step_req = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_phase", cpu_phase, 0);
    n_cpu = 0; n_sd = 0;
    for (int i = 0; i < 12; i++) begin
      n_cpu += int'(cpu_ce); n_sd += int'(step_done);
      tick();
    end
    chk("resume_cpu_ce", n_cpu, 1);
    chk("resume_no_step_done", n_sd, 0);

    // START_HALTED instance: reset in the middle of a step.
    step_h = 1'b1; tick(); step_h = 1'b0;
    n = 0; n_sd = 0;
    while (h_cpu_phase != 4'd6 && n < 20) begin n_sd += int'(h_step_done); tick(); n++; end
    chk("h_reach_phase6", h_cpu_phase, 6);
    chk("h_stepping", h_halted, 0);
    rst_h = 1'b1; tick();
    chk("h_rst_cpu_ce", h_cpu_ce, 0);
    rst_h = 1'b0;
    chk("h_post_rst_halted", h_halted, 1);
    chk("h_post_rst_phase", h_cpu_phase, 0);
    for (int i = 0; i < 20; i++) begin n_sd += int'(h_step_done); tick(); end
    chk("h_no_step_done", n_sd, 0);
    chk("h_count", h_count, 0);
`ifdef NES_CLK_LEVEL_OUT_EN
    chk("h_cpu_clk_halt", h_cpu_clk, 1);
    chk("h_ppu_clk_halt", h_ppu_clk, 1);
`endif

    // Random halt/step/reset traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      step_req = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0; step_req = 1'b0;
    tick();
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
